// File: rtl/mesh_result_streamer.sv
// Drains the mesh result SRAM after collection completes and streams every word out on valid/ready.
// Optional MESH_STREAM_TILE_LAST_EN adds tile_last_o marking the final word of each tile.
`timescale 1ns/1ps
module mesh_result_streamer #(
  parameter int TILE_SIZE  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TILES_X    = 4,
  parameter int TILES_Y    = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int TOTAL     = TILE_SIZE * TILE_SIZE * TILES_X * TILES_Y,
  localparam int AW        = $clog2(TOTAL)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  collection_complete_i,
  output logic                  mem_read_enable_o,
  output logic [AW-1:0]         mem_read_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  input  logic                  mem_read_valid_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
`ifdef MESH_STREAM_TILE_LAST_EN
  output logic                  tile_last_o,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2:0]            state_o
);

  // Stream handshake: a beat transfers on a rising edge where m_valid_o && m_ready_i;
  // once raised, m_valid_o/m_data_o/m_last_o hold until that transfer happens.

  localparam int TILE_AREA = TILE_SIZE * TILE_SIZE;
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_READING = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [AW-1:0]         addr, pend_addr;
  logic                  inflight;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  issue, push, pop;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
`ifdef MESH_STREAM_TILE_LAST_EN
  logic                  fifo_tlast [FIFO_DEPTH];
`endif

  // A read is issued only when a FIFO slot is guaranteed for its data (credit check).
  assign issue = (state == S_READING) && ((count + CW'(inflight)) < DEPTH_C);
  assign push  = mem_read_valid_i && inflight;
  assign pop   = m_valid_o && m_ready_i;

  assign mem_read_enable_o = issue;
  assign mem_read_addr_o   = addr;
  assign m_valid_o         = (count != '0);
  assign m_data_o          = m_valid_o ? fifo_data[rd_ptr] : '0;
  assign m_last_o          = m_valid_o && fifo_last[rd_ptr];
`ifdef MESH_STREAM_TILE_LAST_EN
  assign tile_last_o       = m_valid_o && fifo_tlast[rd_ptr];
`endif
  assign busy_o            = (state != S_IDLE);
  assign done_o            = (state == S_DONE);
  assign state_o           = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_i) state_nxt = collection_complete_i ? S_READING : S_WAIT;
      S_WAIT:    if (collection_complete_i) state_nxt = S_READING;
      S_READING: if (issue && (addr == LAST_ADDR)) state_nxt = S_DRAIN;
      // Leave as soon as the final beat is being popped so done_o follows it directly.
      S_DRAIN:   if (!inflight && ((count == '0) || ((count == CW'(1)) && pop)))
                   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      addr      <= '0;
      pend_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == S_READING) && (state != S_READING)) addr <= '0;
      else if (issue && (addr != LAST_ADDR))                 addr <= addr + AW'(1);
      if (issue) pend_addr <= addr;
      if (issue)                 inflight <= 1'b1;
      else if (mem_read_valid_i) inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the outputs are gated by m_valid_o instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_read_data_i;
      fifo_last[wr_ptr] <= (pend_addr == LAST_ADDR);
`ifdef MESH_STREAM_TILE_LAST_EN
      fifo_tlast[wr_ptr] <= ((int'(pend_addr) % TILE_AREA) == (TILE_AREA - 1));
`endif
    end
  end

endmodule
